pipeline_hazard_ctrl: RTL and testbench

Hazard and scheduling controller for the 5-stage pipelined processor, instantiated once in `Top` beside the register file and ALU. Each cycle it decides whether the fetch/decode front end advances, stalls or is flushed. It resolves three hazard classes: load-use, taken branch, and occupancy of the multi-cycle multiply/divide unit. It also produces the ALU operand forwarding selects for the EX stage.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/fwd_select.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the forwarding selects, the FSM state type and the zero register.
package pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// ALU operand forwarding mux select for one EX-stage source register.
// The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != ZERO) && (mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_reg_write && (wb_rd != ZERO) && (wb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and scheduling controller: load-use, taken-branch and mult/div occupancy
// stalls/flushes for the front end, plus EX-stage operand forwarding selects.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             id_uses_hilo,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             muldiv_busy
);

  localparam logic [REG_W-1:0] ZERO    = REG_W'(REG_ZERO);
  localparam logic [3:0]       OCC_LAT = 4'(MULDIV_LAT);

  hz_state_e  state, state_n;
  logic [3:0] occ, occ_n;
  logic       occ_busy;
  logic       load_use, hilo_hazard, stall, issue;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign occ_busy = (occ != 4'd0);

  assign load_use = ex_mem_read && (ex_rd != ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  assign hilo_hazard = occ_busy && (id_uses_hilo || id_is_muldiv);

  // A taken branch squashes the stalled instruction, so it overrides any stall.
  assign stall = (load_use || hilo_hazard) && !ex_branch_taken;

  assign issue = id_is_muldiv && !stall && !ex_branch_taken && !occ_busy;

  // ---------------------------------------------------------------------------
  // Mult/div occupancy FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      occ   <= 4'd0;
    end else begin
      state <= state_n;
      occ   <= occ_n;
    end
  end

  always_comb begin
    state_n = state;
    occ_n   = occ;
    case (state)
      ST_RUN: begin
        if (issue) begin
          state_n = ST_BUSY;
          occ_n   = OCC_LAT;
        end
      end
      ST_BUSY: begin
        // Branch flushes do not abort the in-flight operation; keep counting.
        occ_n = occ - 4'd1;
        if (occ == 4'd1) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_RUN;
        occ_n   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Front-end control
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign muldiv_busy = occ_busy && !rst;

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src           (ex_rs),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src           (ex_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic             id_uses_rs, id_uses_rt, id_is_muldiv, id_uses_hilo;
  logic             ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, muldiv_busy;
  logic [1:0]       fwd_a, fwd_b;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .REG_W(REG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_muldiv    (id_is_muldiv),
    .id_uses_hilo    (id_uses_hilo),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .muldiv_busy     (muldiv_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: remaining mult/div cycles as a plain integer.
  // ---------------------------------------------------------------------------
  int m_rem = 0;

  function automatic int fwd_model(input int src);
    if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == src) return 2;
    if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == src) return 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit lu, hh;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    hh = (m_rem > 0) && (id_uses_hilo || id_is_muldiv);
    return (lu || hh) && !ex_branch_taken;
  endfunction

  always @(posedge clk) begin
    if (rst)            m_rem <= 0;
    else if (m_rem > 0) m_rem <= m_rem - 1;
    else if (id_is_muldiv && !model_stall() && !ex_branch_taken) m_rem <= LAT;
  end

  always @(negedge clk) begin
    bit st;
    st = model_stall();
    if (rst) begin
      check("m_pc_write",   pc_write,    0);
      check("m_ifid_write", ifid_write,  0);
      check("m_ifid_flush", ifid_flush,  1);
      check("m_idex_flush", idex_flush,  1);
      check("m_fwd_a",      fwd_a,       0);
      check("m_fwd_b",      fwd_b,       0);
      check("m_busy",       muldiv_busy, 0);
    end else begin
      check("m_pc_write",   pc_write,    int'(!st));
      check("m_ifid_write", ifid_write,  int'(!st));
      check("m_ifid_flush", ifid_flush,  int'(ex_branch_taken));
      check("m_idex_flush", idex_flush,  int'(ex_branch_taken || st));
      check("m_fwd_a",      fwd_a,       fwd_model(int'(ex_rs)));
      check("m_fwd_b",      fwd_b,       fwd_model(int'(ex_rt)));
      check("m_busy",       muldiv_busy, int'(m_rem > 0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    rst = 0;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_muldiv = 0; id_uses_hilo = 0;
    ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0; ex_branch_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    sample();
    check("rst_pc_write",   pc_write,   0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_flush", idex_flush, 1);
    check("rst_busy",       muldiv_busy, 0);

    // Load-use: lw $t0 in EX, add $t1,$t0,$t0 in ID.
    next_cycle(); clear_inputs();
    ex_mem_read = 1; ex_rd = 8;
    id_rs = 8; id_rt = 8; id_uses_rs = 1; id_uses_rt = 1;
    sample();
    check("lu_pc_write",   pc_write,   0);
    check("lu_ifid_write", ifid_write, 0);
    check("lu_idex_flush", idex_flush, 1);
    check("lu_ifid_flush", ifid_flush, 0);
    // Load has moved to MEM, bubble in EX: add proceeds with forwarding from EX/MEM.
    next_cycle(); clear_inputs();
    mem_rd = 8; mem_reg_write = 1; ex_rs = 8; ex_rt = 8;
    id_rs = 8; id_uses_rs = 1;
    sample();
    check("lu_after_pc_write", pc_write, 1);
    check("lu_after_fwd_a",    fwd_a,    2);

    // Forwarding priority and register 0.
    next_cycle(); clear_inputs();
    mem_rd = 9; wb_rd = 9; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 9; ex_rt = 9;
    sample();
    check("fwd_exmem", fwd_a, 2);
    next_cycle(); mem_reg_write = 0;
    sample();
    check("fwd_memwb",   fwd_a, 1);
    check("fwd_memwb_b", fwd_b, 1);
    next_cycle(); ex_rs = 0; wb_rd = 0;
    sample();
    check("fwd_zero", fwd_a, 0);

    // Branch resolved taken alongside a load-use condition.
    next_cycle(); clear_inputs();
    ex_mem_read = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1; ex_branch_taken = 1;
    sample();
    check("br_pc_write",   pc_write,   1);
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_flush", idex_flush, 1);

    // Mult/div issue followed by mflo.
    next_cycle(); clear_inputs();
    id_is_muldiv = 1;
    sample();
    check("md_issue_busy", muldiv_busy, 0);
    check("md_issue_pc",   pc_write,    1);
    for (int i = 0; i < LAT; i++) begin
      next_cycle(); clear_inputs();
      id_uses_hilo = 1;
      sample();
      check("md_busy",  muldiv_busy, 1);
      check("md_stall", pc_write,    0);
    end
    next_cycle();
    sample();
    check("md_done_busy", muldiv_busy, 0);
    check("md_done_pc",   pc_write,    1);

    // Reset pulsed two cycles after an issue.
    next_cycle(); clear_inputs();
    id_is_muldiv = 1;
    next_cycle(); clear_inputs();
    next_cycle();
    sample();
    check("rb_busy_before", muldiv_busy, 1);
    next_cycle(); rst = 1; id_uses_hilo = 1;
    sample();
    check("rb_rst_busy", muldiv_busy, 0);
    check("rb_rst_pc",   pc_write,    0);
    next_cycle(); rst = 0;
    sample();
    check("rb_after_busy", muldiv_busy, 0);
    check("rb_after_pc",   pc_write,    1);

    // Randomized traffic on a small register set to force collisions.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst             = ($urandom_range(0, 99) == 0);
      id_rs           = REG_W'($urandom_range(0, 3));
      id_rt           = REG_W'($urandom_range(0, 3));
      ex_rs           = REG_W'($urandom_range(0, 3));
      ex_rt           = REG_W'($urandom_range(0, 3));
      ex_rd           = REG_W'($urandom_range(0, 3));
      mem_rd          = REG_W'($urandom_range(0, 3));
      wb_rd           = REG_W'($urandom_range(0, 3));
      id_uses_rs      = $urandom_range(0, 1) == 1;
      id_uses_rt      = $urandom_range(0, 1) == 1;
      id_is_muldiv    = ($urandom_range(0, 5) == 0);
      id_uses_hilo    = ($urandom_range(0, 3) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      mem_reg_write   = $urandom_range(0, 1) == 1;
      wb_reg_write    = $urandom_range(0, 1) == 1;
      ex_branch_taken = ($urandom_range(0, 7) == 0);
    end

    sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
